// File: rtl/mips_pkg.sv
// Shared definitions for the pipelined MIPS core: widths, ALU operation codes
// and the operand-forwarding select encoding.
package mips_pkg;

  localparam int DATA_W     = 32;
  localparam int REG_ADDR_W = 5;
  localparam int OP_W       = 4;

  typedef enum logic [OP_W-1:0] {
    ALU_AND = 4'b0000,
    ALU_OR  = 4'b0001,
    ALU_NOR = 4'b0010,
    ALU_ADD = 4'b0011,
    ALU_SUB = 4'b0100,
    ALU_INC = 4'b1001
  } alu_op_e;

  typedef enum logic [1:0] {
    FWD_REG   = 2'd0,
    FWD_EXMEM = 2'd1,
    FWD_MEMWB = 2'd2
  } fwd_sel_e;

endpackage

// File: rtl/forwarding_unit.sv
// Read-after-write hazard resolver: chooses where each EX source operand comes
// from. EX/MEM is younger than MEM/WB so it wins; register 0 never forwards.
module forwarding_unit
  import mips_pkg::*;
#(
  parameter int REG_ADDR_WIDTH = REG_ADDR_W
) (
  input  logic [REG_ADDR_WIDTH-1:0] rs_addr_i,
  input  logic [REG_ADDR_WIDTH-1:0] rt_addr_i,
  input  logic                      exmem_reg_write_i,
  input  logic [REG_ADDR_WIDTH-1:0] exmem_rd_i,
  input  logic                      memwb_reg_write_i,
  input  logic [REG_ADDR_WIDTH-1:0] memwb_rd_i,
  output fwd_sel_e                  fwd_a_sel_o,
  output fwd_sel_e                  fwd_b_sel_o
);

  function automatic fwd_sel_e pick_src(input logic [REG_ADDR_WIDTH-1:0] src);
    if (exmem_reg_write_i && (exmem_rd_i != '0) && (exmem_rd_i == src))
      return FWD_EXMEM;
    else if (memwb_reg_write_i && (memwb_rd_i != '0) && (memwb_rd_i == src))
      return FWD_MEMWB;
    else
      return FWD_REG;
  endfunction

  always_comb begin
    fwd_a_sel_o = pick_src(rs_addr_i);
    fwd_b_sel_o = pick_src(rt_addr_i);
  end

endmodule

// File: rtl/id_ex_operand_stage.sv
// ID/EX pipeline register with ALU operand selection. Define FORWARDING_EN to
// build in EX/MEM and MEM/WB operand forwarding; otherwise registered data is used.
module id_ex_operand_stage
  import mips_pkg::*;
#(
  parameter int DATA_WIDTH     = DATA_W,
  parameter int REG_ADDR_WIDTH = REG_ADDR_W,
  parameter int OP_WIDTH       = OP_W
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      stall,
  input  logic                      flush,
  input  logic                      id_valid,
  input  logic [OP_WIDTH-1:0]       id_alu_op,
  input  logic                      id_alu_src,
  input  logic                      id_reg_write,
  input  logic [REG_ADDR_WIDTH-1:0] id_rs_addr,
  input  logic [REG_ADDR_WIDTH-1:0] id_rt_addr,
  input  logic [REG_ADDR_WIDTH-1:0] id_rd_addr,
  input  logic [DATA_WIDTH-1:0]     id_rs_data,
  input  logic [DATA_WIDTH-1:0]     id_rt_data,
  input  logic [DATA_WIDTH-1:0]     id_imm,
  input  logic                      exmem_reg_write,
  input  logic [REG_ADDR_WIDTH-1:0] exmem_rd,
  input  logic [DATA_WIDTH-1:0]     exmem_result,
  input  logic                      memwb_reg_write,
  input  logic [REG_ADDR_WIDTH-1:0] memwb_rd,
  input  logic [DATA_WIDTH-1:0]     memwb_result,
  output logic                      ex_valid,
  output logic [OP_WIDTH-1:0]       ex_alu_operation,
  output logic [DATA_WIDTH-1:0]     ex_a,
  output logic [DATA_WIDTH-1:0]     ex_b,
  output logic [DATA_WIDTH-1:0]     ex_store_data,
  output logic                      ex_reg_write,
  output logic [REG_ADDR_WIDTH-1:0] ex_rd
);

  logic                      valid_q,   valid_d;
  logic [OP_WIDTH-1:0]       alu_op_q,  alu_op_d;
  logic                      alu_src_q, alu_src_d;
  logic                      reg_wr_q,  reg_wr_d;
  logic [REG_ADDR_WIDTH-1:0] rs_addr_q, rs_addr_d;
  logic [REG_ADDR_WIDTH-1:0] rt_addr_q, rt_addr_d;
  logic [REG_ADDR_WIDTH-1:0] rd_addr_q, rd_addr_d;
  logic [DATA_WIDTH-1:0]     rs_data_q, rs_data_d;
  logic [DATA_WIDTH-1:0]     rt_data_q, rt_data_d;
  logic [DATA_WIDTH-1:0]     imm_q,     imm_d;

  logic [DATA_WIDTH-1:0]     rs_fwd;
  logic [DATA_WIDTH-1:0]     rt_fwd;

  // Next state: flush beats stall beats load; reset is applied in the register.
  always_comb begin
    valid_d   = valid_q;
    alu_op_d  = alu_op_q;
    alu_src_d = alu_src_q;
    reg_wr_d  = reg_wr_q;
    rs_addr_d = rs_addr_q;
    rt_addr_d = rt_addr_q;
    rd_addr_d = rd_addr_q;
    rs_data_d = rs_data_q;
    rt_data_d = rt_data_q;
    imm_d     = imm_q;
    if (flush) begin
      valid_d   = 1'b0;
      alu_op_d  = '0;
      alu_src_d = 1'b0;
      reg_wr_d  = 1'b0;
      rs_addr_d = '0;
      rt_addr_d = '0;
      rd_addr_d = '0;
      rs_data_d = '0;
      rt_data_d = '0;
      imm_d     = '0;
    end else if (!stall) begin
      valid_d   = id_valid;
      alu_op_d  = id_alu_op;
      alu_src_d = id_alu_src;
      reg_wr_d  = id_reg_write;
      rs_addr_d = id_rs_addr;
      rt_addr_d = id_rt_addr;
      rd_addr_d = id_rd_addr;
      rs_data_d = id_rs_data;
      rt_data_d = id_rt_data;
      imm_d     = id_imm;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q   <= 1'b0;
      alu_op_q  <= '0;
      alu_src_q <= 1'b0;
      reg_wr_q  <= 1'b0;
      rs_addr_q <= '0;
      rt_addr_q <= '0;
      rd_addr_q <= '0;
      rs_data_q <= '0;
      rt_data_q <= '0;
      imm_q     <= '0;
    end else begin
      valid_q   <= valid_d;
      alu_op_q  <= alu_op_d;
      alu_src_q <= alu_src_d;
      reg_wr_q  <= reg_wr_d;
      rs_addr_q <= rs_addr_d;
      rt_addr_q <= rt_addr_d;
      rd_addr_q <= rd_addr_d;
      rs_data_q <= rs_data_d;
      rt_data_q <= rt_data_d;
      imm_q     <= imm_d;
    end
  end

`ifdef FORWARDING_EN
  fwd_sel_e fwd_a_sel;
  fwd_sel_e fwd_b_sel;

  forwarding_unit #(
    .REG_ADDR_WIDTH(REG_ADDR_WIDTH)
  ) u_forwarding_unit (
    .rs_addr_i         (rs_addr_q),
    .rt_addr_i         (rt_addr_q),
    .exmem_reg_write_i (exmem_reg_write),
    .exmem_rd_i        (exmem_rd),
    .memwb_reg_write_i (memwb_reg_write),
    .memwb_rd_i        (memwb_rd),
    .fwd_a_sel_o       (fwd_a_sel),
    .fwd_b_sel_o       (fwd_b_sel)
  );

  function automatic logic [DATA_WIDTH-1:0] fwd_pick(input fwd_sel_e sel,
                                                     input logic [DATA_WIDTH-1:0] reg_val);
    case (sel)
      FWD_EXMEM: return exmem_result;
      FWD_MEMWB: return memwb_result;
      default:   return reg_val;
    endcase
  endfunction

  // Forward buses reach the ALU combinationally, even while the stage is stalled.
  always_comb begin
    rs_fwd = fwd_pick(fwd_a_sel, rs_data_q);
    rt_fwd = fwd_pick(fwd_b_sel, rt_data_q);
  end
`else
  logic unused_fwd_inputs;

  assign rs_fwd = rs_data_q;
  assign rt_fwd = rt_data_q;
  assign unused_fwd_inputs = ^{exmem_reg_write, exmem_rd, exmem_result,
                               memwb_reg_write, memwb_rd, memwb_result,
                               rs_addr_q, rt_addr_q};
`endif

  assign ex_valid         = valid_q;
  assign ex_alu_operation = alu_op_q;
  assign ex_a             = rs_fwd;
  assign ex_b             = alu_src_q ? imm_q : rt_fwd;
  assign ex_store_data    = rt_fwd;
  assign ex_reg_write     = reg_wr_q & valid_q;
  assign ex_rd            = rd_addr_q;

endmodule
